// File: rtl/reg_file_cc.sv
// rtl/reg_file_cc.sv - general-purpose register file with NZP condition codes and branch-enable flag
module reg_file_cc #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] BUS,
  input  logic [15:0]      IR,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  output logic [WIDTH-1:0] SR1OUT,
  output logic [WIDTH-1:0] SR2OUT,
  output logic [2:0]       NZP,
  output logic             BEN
);

  localparam int NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs [NREG];
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] sr1_idx;
  logic [ADDR_W-1:0] sr2_idx;
  logic [2:0]        nzp_q;
  logic [2:0]        nzp_next;
  logic              ben_q;

  // Destination is either the IR DR field or the top register (link register).
  assign dest    = DRMUX ? '1 : IR[11:9];
  assign sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
  assign sr2_idx = IR[2:0];

  // Reads are combinational with no write bypass: a same-cycle write shows up after the edge.
  assign SR1OUT = regs[sr1_idx];
  assign SR2OUT = regs[sr2_idx];
  assign NZP    = nzp_q;
  assign BEN    = ben_q;

  // Classify BUS into exactly one of negative / zero / positive.
  always_comb begin
    nzp_next = 3'b001;
    if (BUS[WIDTH-1]) begin
      nzp_next = 3'b100;
    end else if (BUS == '0) begin
      nzp_next = 3'b010;
    end
  end

  // Register array writeback from BUS; reset clears every entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (LD_REG) begin
      regs[dest] <= BUS;
    end
  end

  // Condition codes come out of reset as Z so they stay one-hot from the start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      nzp_q <= 3'b010;
    end else if (LD_CC) begin
      nzp_q <= nzp_next;
    end
  end

  // BEN samples the pre-edge NZP, so a simultaneous LD_CC does not affect it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ben_q <= 1'b0;
    end else if (LD_BEN) begin
      ben_q <= |(IR[11:9] & nzp_q);
    end
  end

endmodule

// File: tb/tb_reg_file_cc.sv
// tb/tb_reg_file_cc.sv - directed scoreboard bench for reg_file_cc
module tb_reg_file_cc;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] BUS;
  logic [15:0] IR;
  logic        DRMUX;
  logic        SR1MUX;
  logic        LD_REG;
  logic        LD_CC;
  logic        LD_BEN;
  logic [15:0] SR1OUT;
  logic [15:0] SR2OUT;
  logic [2:0]  NZP;
  logic        BEN;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  reg_file_cc #(.WIDTH(16), .ADDR_W(3)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .BUS    (BUS),
    .IR     (IR),
    .DRMUX  (DRMUX),
    .SR1MUX (SR1MUX),
    .LD_REG (LD_REG),
    .LD_CC  (LD_CC),
    .LD_BEN (LD_BEN),
    .SR1OUT (SR1OUT),
    .SR2OUT (SR2OUT),
    .NZP    (NZP),
    .BEN    (BEN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] mk_ir(input logic [2:0] dr, input logic [2:0] sr1, input logic [2:0] sr2);
    return {4'b0000, dr, sr1, 3'b000, sr2};
  endfunction

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset_n = 1'b0;
    BUS     = 16'h0000;
    IR      = 16'h0000;
    DRMUX   = 1'b0;
    SR1MUX  = 1'b0;
    LD_REG  = 1'b0;
    LD_CC   = 1'b0;
    LD_BEN  = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;

    // Load R3 and negative CC so the mid-cycle reset has something to clear.
    IR = mk_ir(3'd3, 3'd0, 3'd3); BUS = 16'hBEEF; LD_REG = 1'b1; LD_CC = 1'b1;
    push("pre_rst_r3", 16'hBEEF);
    push("pre_rst_nzp", 16'h0004);
    tick();
    check(SR2OUT);
    check({13'b0, NZP});

    // Asynchronous reset with a write pending.
    BUS = 16'hCAFE; LD_CC = 1'b0;
    #1;
    Reset_n = 1'b0;
    #1;
    push("rst_sr1", 16'h0000);
    push("rst_sr2", 16'h0000);
    push("rst_nzp", 16'h0002);
    push("rst_ben", 16'h0000);
    check(SR1OUT);
    check(SR2OUT);
    check({13'b0, NZP});
    check({15'b0, BEN});
    tick();
    push("rst_held_r3", 16'h0000);
    check(SR2OUT);

    // Release mid-cycle; first write lands on the next edge.
    Reset_n = 1'b1;
    BUS = 16'h1234;
    push("post_rst_before", 16'h0000);
    check(SR2OUT);
    push("post_rst_r3", 16'h1234);
    tick();
    check(SR2OUT);

    // Read-during-write: old value until the edge, new after.
    IR = mk_ir(3'd5, 3'd5, 3'd0); BUS = 16'h00AA;
    tick();
    SR1MUX = 1'b1; BUS = 16'h5555;
    #1;
    push("rdw_before", 16'h00AA);
    check(SR1OUT);
    push("rdw_after", 16'h5555);
    tick();
    check(SR1OUT);

    // DRMUX=1 targets R7, leaving the IR DR field register alone.
    DRMUX = 1'b1; IR = mk_ir(3'd2, 3'd7, 3'd2); BUS = 16'h3001;
    push("drmux_r7", 16'h3001);
    push("drmux_r2", 16'h0000);
    tick();
    LD_REG = 1'b0; DRMUX = 1'b0;
    check(SR1OUT);
    check(SR2OUT);

    // LD_REG=0 ignores BUS.
    BUS = 16'hDEAD;
    push("noload_r7", 16'h3001);
    tick();
    check(SR1OUT);

    // Condition codes.
    LD_CC = 1'b1; BUS = 16'h8000;
    push("cc_neg", 16'h0004);
    tick();
    check({13'b0, NZP});
    BUS = 16'h0000;
    push("cc_zero", 16'h0002);
    tick();
    check({13'b0, NZP});
    BUS = 16'h7FFF;
    push("cc_pos", 16'h0001);
    tick();
    check({13'b0, NZP});
    LD_CC = 1'b0; BUS = 16'h0000;
    push("cc_hold", 16'h0001);
    tick();
    check({13'b0, NZP});

    // BEN uses pre-edge NZP when LD_CC and LD_BEN coincide.
    IR = mk_ir(3'b001, 3'd0, 3'd0); LD_CC = 1'b1; LD_BEN = 1'b1; BUS = 16'h0000;
    push("ben_old_p", 16'h0001);
    push("ben_nzp_new", 16'h0002);
    tick();
    check({15'b0, BEN});
    check({13'b0, NZP});
    LD_CC = 1'b0;
    push("ben_repeat", 16'h0000);
    tick();
    check({15'b0, BEN});
    IR = mk_ir(3'b010, 3'd0, 3'd0);
    push("ben_z", 16'h0001);
    tick();
    check({15'b0, BEN});
    LD_BEN = 1'b0; IR = mk_ir(3'b000, 3'd0, 3'd0);
    push("ben_hold", 16'h0001);
    tick();
    check({15'b0, BEN});

    // Fill R0..R7 with distinct values, then sweep both ports.
    LD_REG = 1'b1; SR1MUX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      IR  = mk_ir(3'(i), 3'd0, 3'd0);
      BUS = 16'(i) * 16'h1111;
      tick();
    end
    LD_REG = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        SR1MUX = j[0];
        IR = SR1MUX ? mk_ir(3'd0, 3'(i), 3'(j)) : mk_ir(3'(i), 3'd0, 3'(j));
        #1;
        push($sformatf("sweep_sr1_%0d_%0d", i, j), 16'(i) * 16'h1111);
        push($sformatf("sweep_sr2_%0d_%0d", i, j), 16'(j) * 16'h1111);
        check(SR1OUT);
        check(SR2OUT);
      end
    end

    if (sb.size() != 0) begin
      bad++;
      total++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
